exp4_unidade_controle: RTL
==========================

Name: exp4_unidade_controle

Overview:
Moore FSM that sequences the game datapath (position counter, 4-bit move register, 16x4 ROM, comparator). It clears the datapath, waits for each player move, registers it and compares it with the memory word. It advances the address on a hit and finishes on the first miss, on a full sequence of 16 hits, or on a per-move timeout. Instantiated next to the datapath in the top-level circuit.

Parameters:
TIMEOUT, 3000, clock cycles allowed in ESPERA before a timeout ends the round; 0 disables the timeout.
TW, 12, width of the internal timeout counter; must hold TIMEOUT-1.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; forces INICIAL.
iniciar  in  1  start/restart request, level sampled on the clock edge.
jogada  in  1  one-cycle pulse: a move is present on the switches.
igual  in  1  comparator output from the datapath (register == memory).
fimC  in  1  datapath counter at last address (15).
zeraC  out  1  clear the position counter.
contaC  out  1  increment the position counter.
zeraR  out  1  clear the move register.
registraR  out  1  load the move register.
pronto  out  1  round finished.
acertou  out  1  round ended with all 16 hits.
errou  out  1  round ended with a miss or a timeout.
timeout  out  1  round ended by timeout (errou is also 1).
db_estado  out  4  state code for the debug display.

Behaviour:
- Moore outputs only; every output is decoded from the state register alone.
- Reset (asynchronous, any time, including mid-round): state = INICIAL and timeout counter = 0. All outputs are 0 and db_estado = 0000.
- States and codes:
  - INICIAL 0000: iniciar=1 -> PREPARA, else stay.
  - PREPARA 0001: zeraC=1 and zeraR=1 for exactly 1 cycle -> ESPERA. Timeout counter cleared.
  - ESPERA 0010: all strobes 0; timeout counter +1 per cycle.
    - jogada=1 -> REGISTRA.
    - jogada=0 and TIMEOUT!=0 and counter==TIMEOUT-1 -> FIM_TIMEOUT.
    - If both conditions hold in the same cycle, jogada wins.
  - REGISTRA 0100: registraR=1 for 1 cycle -> COMPARA.
  - COMPARA 0101: the register now holds the move.
    - igual=0 -> FIM_ERROU.
    - igual=1 and fimC=1 -> FIM_ACERTOU.
    - igual=1 and fimC=0 -> PROXIMO.
  - PROXIMO 0110: contaC=1 for 1 cycle -> ESPERA. Timeout counter cleared.
  - FIM_ACERTOU 1010: pronto=1, acertou=1.
  - FIM_ERROU 1110: pronto=1, errou=1.
  - FIM_TIMEOUT 1101: pronto=1, errou=1, timeout=1.
  - In all three FIM states, outputs are held while iniciar=0; iniciar=1 -> PREPARA (new round, no pass through INICIAL).
- Latency: jogada pulse in ESPERA to registraR is 1 cycle; registraR to the COMPARA decision is 1 cycle. A hit costs 3 cycles per move before the next ESPERA.
- jogada is ignored in every state except ESPERA. iniciar is ignored except in INICIAL and the FIM states.
- Timeout counter: TW bits; counts only in ESPERA; saturates, never wraps.
- Unused state codes fall back to INICIAL (default branch).
- At most one of zeraC/contaC/registraR is active per cycle. zeraR is asserted only together with zeraC.

Test Plan:
1. Reset pulse mid-count, then iniciar=1 for 1 cycle -> INICIAL (0000), then PREPARA: zeraC=zeraR=1 for 1 cycle, then ESPERA (0010).
2. In ESPERA, jogada pulse with igual=1, fimC=0 -> registraR=1 next cycle, COMPARA (0101), contaC=1 for 1 cycle, back to ESPERA.
3. Sixteen moves with igual=1, fimC=1 on the 16th -> FIM_ACERTOU; pronto=1, acertou=1, errou=0; contaC pulsed exactly 15 times.
4. Third move with igual=0 -> FIM_ERROU; pronto=1, errou=1, acertou=0. Then iniciar=1 -> PREPARA with zeraC pulse.
5. TIMEOUT=10, no jogada -> FIM_TIMEOUT exactly 10 cycles after entering ESPERA; timeout=1, errou=1. Repeat with jogada on cycle 10 -> REGISTRA (jogada wins).
6. Assert reset asynchronously during REGISTRA -> outputs drop to 0 and db_estado=0000 before the next clock edge. Assert jogada in INICIAL -> no state change.

Source files
------------

// File: rtl/exp4_unidade_controle_if.sv
// Control/status bundle between the game control unit (slave) and the
// datapath/top level that feeds it (master).
interface exp4_unidade_controle_if;
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       fimC;
  logic       zeraC;
  logic       contaC;
  logic       zeraR;
  logic       registraR;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  modport master (
    output iniciar, jogada, igual, fimC,
    input  zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado
  );

  modport slave (
    input  iniciar, jogada, igual, fimC,
    output zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado
  );
endinterface

// File: rtl/exp4_unidade_controle.sv
// Moore control unit for the memory game: clears the datapath, waits for each move,
// registers and compares it, and ends the round on a miss, 16 hits or a per-move timeout.
module exp4_unidade_controle #(
  parameter int unsigned TIMEOUT = 3000,
  parameter int unsigned TW      = 12
) (
  input logic                    clock,
  input logic                    reset,
  exp4_unidade_controle_if.slave bus
);

  typedef enum logic [3:0] {
    StInicial    = 4'b0000,
    StPrepara    = 4'b0001,
    StEspera     = 4'b0010,
    StRegistra   = 4'b0100,
    StCompara    = 4'b0101,
    StProximo    = 4'b0110,
    StFimAcertou = 4'b1010,
    StFimErrou   = 4'b1110,
    StFimTimeout = 4'b1101
  } estado_t;

  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TimerMax  = '1;

  estado_t       estadoQ, estadoD;
  logic [TW-1:0] timerQ, timerD;
  logic          timerExpired;

  // TIMEOUT == 0 keeps the comparison permanently false.
  assign timerExpired = (TIMEOUT != 0) && (timerQ == TimerLast);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estadoQ <= StInicial;
      timerQ  <= '0;
    end else begin
      estadoQ <= estadoD;
      timerQ  <= timerD;
    end
  end

  // Timer restarts on every entry into ESPERA and saturates instead of wrapping.
  always_comb begin
    timerD = timerQ;
    case (estadoQ)
      StPrepara, StProximo: timerD = '0;
      StEspera:             if (timerQ != TimerMax) timerD = timerQ + 1'b1;
      default:              timerD = timerQ;
    endcase
  end

  always_comb begin
    estadoD = estadoQ;
    case (estadoQ)
      StInicial:  if (bus.iniciar) estadoD = StPrepara;
      StPrepara:  estadoD = StEspera;
      StEspera: begin
        if (bus.jogada) begin
          estadoD = StRegistra;
        end else if (timerExpired) begin
          estadoD = StFimTimeout;
        end
      end
      StRegistra: estadoD = StCompara;
      StCompara: begin
        if (!bus.igual) begin
          estadoD = StFimErrou;
        end else if (bus.fimC) begin
          estadoD = StFimAcertou;
        end else begin
          estadoD = StProximo;
        end
      end
      StProximo:  estadoD = StEspera;
      StFimAcertou, StFimErrou, StFimTimeout: begin
        if (bus.iniciar) estadoD = StPrepara;
      end
      default:    estadoD = StInicial;
    endcase
  end

  always_comb begin
    bus.zeraC     = 1'b0;
    bus.contaC    = 1'b0;
    bus.zeraR     = 1'b0;
    bus.registraR = 1'b0;
    bus.pronto    = 1'b0;
    bus.acertou   = 1'b0;
    bus.errou     = 1'b0;
    bus.timeout   = 1'b0;
    bus.db_estado = estadoQ;
    case (estadoQ)
      StPrepara: begin
        bus.zeraC = 1'b1;
        bus.zeraR = 1'b1;
      end
      StRegistra: bus.registraR = 1'b1;
      StProximo:  bus.contaC = 1'b1;
      StFimAcertou: begin
        bus.pronto  = 1'b1;
        bus.acertou = 1'b1;
      end
      StFimErrou: begin
        bus.pronto = 1'b1;
        bus.errou  = 1'b1;
      end
      StFimTimeout: begin
        bus.pronto  = 1'b1;
        bus.errou   = 1'b1;
        bus.timeout = 1'b1;
      end
      default: bus.db_estado = estadoQ;
    endcase
  end

  strobesExclusive: assert property (@(posedge clock) disable iff (reset)
    $onehot0({bus.zeraC, bus.contaC, bus.registraR}));

  zeraRWithZeraC: assert property (@(posedge clock) disable iff (reset)
    bus.zeraR |-> bus.zeraC);

endmodule
